// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared HI/LO op encodings, controller states and handshake levels for the EX-stage mul/div sequencer.
package hilo_muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } hilo_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_WAIT,
    S_DIV_WAIT,
    S_DONE
  } hilo_state_e;

  localparam logic DIV_START        = 1'b1;
  localparam logic DIV_STOP         = 1'b0;
  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic STOP             = 1'b1;
  localparam logic NO_STOP          = 1'b0;

  function automatic logic op_is_signed(input hilo_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_hilo_reg.sv
// HI/LO architectural register pair; independent write enables, 1-cycle write, never stalls.
module hilo_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hi_d,
  input  logic [31:0] lo_d,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else begin
      if (hi_we) hi <= hi_d;
      if (lo_we) lo <= lo_d;
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Sequences mul/div for EX and owns HI/LO; multiply stalls MUL_LAT cycles, divide until div_ready.
// Results wait in DONE until ex_advance commits them; flush/rst kill the op without a commit.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        ex_advance,
  output logic        stallreq,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_signed,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  output logic        div_start,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  hilo_op_e         op_dec;
  hilo_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      res_q, res_d;
  logic [31:0]      opa_q, opb_q;
  logic             sgn_q;
  logic             opnd_we;
  logic             kill, idle, is_mul, is_div, mul_accept;
  logic             hi_we, lo_we;
  logic [31:0]      hi_d, lo_d;

  assign op_dec     = hilo_op_e'(op);
  assign kill       = flush | rst;
  assign idle       = (state_q == S_IDLE);
  assign is_mul     = op_valid && ((op_dec == OP_MULT) || (op_dec == OP_MULTU));
  assign is_div     = op_valid && ((op_dec == OP_DIV) || (op_dec == OP_DIVU));
  assign mul_accept = idle && is_mul && !kill;

  // The multiplier sees the live operands in the accept cycle so MUL_LAT counts from there.
  assign mul_ina    = mul_accept ? src1 : opa_q;
  assign mul_inb    = mul_accept ? src2 : opb_q;
  assign mul_signed = mul_accept ? op_is_signed(op_dec) : sgn_q;

  assign div_op1    = opa_q;
  assign div_op2    = opb_q;
  assign div_signed = sgn_q;
  assign div_start  = (state_q == S_DIV_WAIT) ? DIV_START : DIV_STOP;
  assign div_annul  = kill && (state_q == S_DIV_WAIT);

  assign busy    = !idle;
  assign rd_data = (op_dec == OP_MFHI) ? hi_o : lo_o;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    opnd_we  = 1'b0;
    stallreq = NO_STOP;
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    hi_d     = res_q[63:32];
    lo_d     = res_q[31:0];

    if (kill) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_mul) begin
            opnd_we  = 1'b1;
            stallreq = STOP;
            if (MUL_LAT == 1) begin
              res_d   = mul_result;
              state_d = S_DONE;
            end else begin
              cnt_d   = CNT_W'(MUL_LAT - 1);
              state_d = S_MUL_WAIT;
            end
          end else if (is_div) begin
            stallreq = STOP;
            if (src2 == 32'd0) begin
              res_d   = 64'd0;
              state_d = S_DONE;
            end else begin
              opnd_we = 1'b1;
              state_d = S_DIV_WAIT;
            end
          end else if (op_valid && ex_advance) begin
            if (op_dec == OP_MTHI) begin
              hi_we = 1'b1;
              hi_d  = src1;
            end
            if (op_dec == OP_MTLO) begin
              lo_we = 1'b1;
              lo_d  = src1;
            end
          end
        end
        S_MUL_WAIT: begin
          stallreq = STOP;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            res_d   = mul_result;
            state_d = S_DONE;
          end
        end
        S_DIV_WAIT: begin
          stallreq = STOP;
          if (div_ready == DIV_RESULT_READY) begin
            res_d   = div_result;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          // The op is still presented here; only an advancing EX retires it.
          if (ex_advance) begin
            hi_we   = 1'b1;
            lo_we   = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= 64'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      if (opnd_we) begin
        opa_q <= src1;
        opb_q <= src2;
        sgn_q <= op_is_signed(op_dec);
      end
    end
  end

  hilo_reg u_hilo_reg (
    .clk   (clk),
    .rst   (rst),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .hi_d  (hi_d),
    .lo_d  (lo_d),
    .hi    (hi_o),
    .lo    (lo_o)
  );

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Bench for hilo_muldiv_ctrl: vector table, corner sequences and random ops against an arithmetic HI/LO model.
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

  localparam int MUL_LAT = 2;
  localparam int DIV_CYC = 33;

  logic        clk, rst, flush, op_valid, ex_advance;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        stallreq, busy;
  logic [31:0] rd_data, hi_o, lo_o;
  logic        mul_signed, div_signed, div_start, div_annul, div_ready;
  logic [31:0] mul_ina, mul_inb, div_op1, div_op2;
  logic [63:0] mul_result, div_result;

  int checks = 0;
  int errors = 0;

  hilo_muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op(op),
    .src1(src1), .src2(src2), .ex_advance(ex_advance), .stallreq(stallreq),
    .busy(busy), .rd_data(rd_data), .hi_o(hi_o), .lo_o(lo_o),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
    .mul_result(mul_result), .div_signed(div_signed), .div_op1(div_op1),
    .div_op2(div_op2), .div_start(div_start), .div_annul(div_annul),
    .div_result(div_result), .div_ready(div_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] xa, xb;
    xa = s ? {{32{a[31]}}, a} : {32'd0, a};
    xb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return 64'(xa * xb);
  endfunction

  function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b, input logic s);
    int sa, sb;
    if (s) begin
      sa = a;
      sb = b;
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  function automatic logic [63:0] ref_hilo(input hilo_op_e o, input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] hi, input logic [31:0] lo);
    case (o)
      OP_MULT:  return mul64(a, b, 1'b1);
      OP_MULTU: return mul64(a, b, 1'b0);
      OP_DIV:   return (b == 32'd0) ? 64'd0 : div64(a, b, 1'b1);
      OP_DIVU:  return (b == 32'd0) ? 64'd0 : div64(a, b, 1'b0);
      OP_MTHI:  return {a, lo};
      OP_MTLO:  return {hi, a};
      default:  return {hi, lo};
    endcase
  endfunction

  // Pipelined multiplier: result appears one cycle after its operands.
  logic [63:0] mul_pipe;
  always @(posedge clk) mul_pipe <= mul64(mul_ina, mul_inb, mul_signed);
  assign mul_result = mul_pipe;

  // Iterative divider: fixed DIV_CYC cycles, one-cycle ready pulse, aborted by annul.
  logic        d_busy, d_ready;
  int          d_cnt;
  logic [31:0] d_a, d_b;
  logic        d_s;
  logic [63:0] d_res;
  always @(posedge clk) begin
    d_ready <= 1'b0;
    if (rst || div_annul) begin
      d_busy <= 1'b0;
    end else if (d_busy) begin
      if (d_cnt == 1) begin
        d_busy  <= 1'b0;
        d_ready <= 1'b1;
        d_res   <= div64(d_a, d_b, d_s);
      end else begin
        d_cnt <= d_cnt - 1;
      end
    end else if (div_start && !d_ready) begin
      d_busy <= 1'b1;
      d_cnt  <= DIV_CYC;
      d_a    <= div_op1;
      d_b    <= div_op2;
      d_s    <= div_signed;
    end
  end
  assign div_ready  = d_ready;
  assign div_result = d_res;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present one op, let EX advance once the stall drops (after `hold` extra DONE cycles), then check.
  task automatic exec(input hilo_op_e o, input logic [31:0] a, input logic [31:0] b, input int hold,
                      input int exp_stall, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int stalls, starts, waited, hold_left;
    bit prev_ready, end_ready, seen_end, stable_ok, hold_ok, done, is_mul, div_nz;
    logic [31:0] hi0, lo0;
    stalls = 0; starts = 0; waited = 0; hold_left = hold;
    prev_ready = 0; end_ready = 0; seen_end = 0; stable_ok = 1; hold_ok = 1; done = 0;
    is_mul = (o == OP_MULT) || (o == OP_MULTU);
    div_nz = ((o == OP_DIV) || (o == OP_DIVU)) && (b != 32'd0);
    @(posedge clk); #1;
    hi0 = hi_o; lo0 = lo_o;
    op_valid = 1'b1; op = o; src1 = a; src2 = b; ex_advance = 1'b0;
    while (!done) begin
      #1;
      if (stallreq) begin
        stalls++;
        if (seen_end) hold_ok = 0;
        if (is_mul && (mul_ina !== a || mul_inb !== b)) stable_ok = 0;
      end else begin
        if (!seen_end) begin
          seen_end  = 1;
          end_ready = prev_ready;
        end
        if (hold_left > 0) begin
          hold_left--;
          if (!busy || hi_o !== hi0 || lo_o !== lo0) hold_ok = 0;
        end else begin
          ex_advance = 1'b1;
          done = 1;
        end
      end
      if (div_start) starts++;
      prev_ready = div_ready;
      waited++;
      if (waited > 400) begin
        checks++;
        errors++;
        $display("FAIL exec_timeout: op %0d not retired after %0d cycles, required completion", o, waited);
        flush = 1'b1;
        done = 1;
      end
      @(posedge clk); #1;
    end
    op_valid = 1'b0; ex_advance = 1'b0; flush = 1'b0;
    if (exp_stall >= 0) chk("stall_cycles", 64'(stalls), 64'(exp_stall));
    if (div_nz) chk("stall_ends_after_ready", 64'(end_ready), 64'd1);
    chk("div_start_cycles", 64'(starts), div_nz ? 64'(stalls - 1) : 64'd0);
    if (is_mul) chk("mul_operands_stable", 64'(stable_ok), 64'd1);
    if (hold > 0) chk("done_hold_no_restart", 64'(hold_ok), 64'd1);
    chk("hi", 64'(hi_o), 64'(exp_hi));
    chk("lo", 64'(lo_o), 64'(exp_lo));
    chk("busy_after_commit", 64'(busy), 64'd0);
  endtask

  typedef struct {
    hilo_op_e    o;
    logic [31:0] a, b;
    int          hold, stall;
    logic [31:0] hi, lo;
  } vec_t;

  vec_t        vecs[12];
  hilo_op_e    ro;
  logic [31:0] ra, rb, ref_hi, ref_lo, hi0, lo0;
  logic [63:0] nxt;
  int          rhold, rstall, readies;

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        0,  2, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1]  = '{OP_DIVU,  32'd100,       32'd7,        0, -1, 32'd2,         32'd14};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        0, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{OP_DIV,   32'd5,         32'd0,        0,  1, 32'd0,         32'd0};
    vecs[4]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 2, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[5]  = '{OP_MULT,  32'd7,         32'd6,        3,  2, 32'd0,         32'd42};
    vecs[6]  = '{OP_DIVU,  32'd1000,      32'd3,        3, -1, 32'd1,         32'd333};
    vecs[7]  = '{OP_MTHI,  32'hA5A5_0000, 32'd0,        0,  0, 32'hA5A5_0000, 32'd333};
    vecs[8]  = '{OP_MTLO,  32'h0000_1234, 32'd0,        0,  0, 32'hA5A5_0000, 32'h0000_1234};
    vecs[9]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 0, -1, 32'd1,        32'hFFFF_FFFD};
    vecs[10] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd0,        0,  1, 32'd0,         32'd0};
    vecs[11] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 0, 2, 32'h4000_0000, 32'd0};

    rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op = 3'd0; src1 = 32'd0; src2 = 32'd0; ex_advance = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_hi", 64'(hi_o), 64'd0);
    chk("reset_lo", 64'(lo_o), 64'd0);
    chk("reset_stallreq", 64'(stallreq), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rd_data", 64'(rd_data), 64'd0);
    chk("reset_div_start", 64'(div_start), 64'd0);
    chk("reset_div_annul", 64'(div_annul), 64'd0);
    chk("reset_mul_ina", 64'(mul_ina), 64'd0);

    foreach (vecs[i]) begin
      exec(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].stall, vecs[i].hi, vecs[i].lo);
      ref_hi = vecs[i].hi;
      ref_lo = vecs[i].lo;
    end

    // MTHI then MFHI in the very next cycle.
    exec(OP_MTHI, 32'hA5A5_0000, 32'd0, 0, 0, 32'hA5A5_0000, ref_lo);
    ref_hi = 32'hA5A5_0000;
    op_valid = 1'b1; op = OP_MFHI; ex_advance = 1'b1;
    #1;
    chk("mfhi_rd_data", 64'(rd_data), 64'h0000_0000_A5A5_0000);
    chk("mfhi_no_stall", 64'(stallreq), 64'd0);
    op = OP_MFLO;
    #1;
    chk("mflo_rd_data", 64'(rd_data), 64'(ref_lo));
    op_valid = 1'b0; ex_advance = 1'b0;

    // Flush five cycles into a DIVU: annul pulse, no commit, divider never answers.
    hi0 = hi_o; lo0 = lo_o;
    @(posedge clk); #1;
    op_valid = 1'b1; op = OP_DIVU; src1 = 32'd1000; src2 = 32'd3;
    repeat (5) @(posedge clk);
    #1 flush = 1'b1;
    #1 chk("flush_div_annul", 64'(div_annul), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_div_annul_drop", 64'(div_annul), 64'd0);
    chk("flush_hi_kept", 64'(hi_o), 64'(hi0));
    chk("flush_lo_kept", 64'(lo_o), 64'(lo0));
    readies = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (div_ready || div_start) readies++;
    end
    chk("flush_divider_quiet", 64'(readies), 64'd0);
    exec(OP_MTLO, 32'h0000_1234, 32'd0, 0, 0, hi0, 32'h0000_1234);
    ref_hi = hi0; ref_lo = 32'h0000_1234;

    // flush beats ex_advance in DONE.
    @(posedge clk); #1;
    op_valid = 1'b1; op = OP_MULT; src1 = 32'd9; src2 = 32'd9;
    repeat (2) @(posedge clk);
    #1 ex_advance = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; ex_advance = 1'b0; op_valid = 1'b0;
    chk("flush_over_advance_hi", 64'(hi_o), 64'(ref_hi));
    chk("flush_over_advance_lo", 64'(lo_o), 64'(ref_lo));
    chk("flush_over_advance_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 40; i++) begin
      ro = hilo_op_e'($urandom_range(0, 5));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      else if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 20);
      if (ro == OP_DIV && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      rhold = (ro <= OP_DIVU) ? $urandom_range(0, 2) : 0;
      case (ro)
        OP_MULT, OP_MULTU: rstall = MUL_LAT;
        OP_DIV, OP_DIVU:   rstall = (rb == 32'd0) ? 1 : -1;
        default:           rstall = 0;
      endcase
      nxt = ref_hilo(ro, ra, rb, ref_hi, ref_lo);
      exec(ro, ra, rb, rhold, rstall, nxt[63:32], nxt[31:0]);
      ref_hi = nxt[63:32];
      ref_lo = nxt[31:0];
      if (i % 4 == 0) begin
        op_valid = 1'b1;
        op = (i % 8 == 0) ? OP_MFHI : OP_MFLO;
        #1 chk("rand_mf_rd_data", 64'(rd_data), (i % 8 == 0) ? 64'(ref_hi) : 64'(ref_lo));
        op_valid = 1'b0;
      end
    end

    // Reset in the middle of a multiply clears HI/LO.
    @(posedge clk); #1;
    op_valid = 1'b1; op = OP_MULT; src1 = 32'd5; src2 = 32'd5;
    @(posedge clk); #1;
    rst = 1'b1; op_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_op_hi", 64'(hi_o), 64'd0);
    chk("rst_mid_op_lo", 64'(lo_o), 64'd0);
    chk("rst_mid_op_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
